// File: rtl/lod_pkg.sv
// Shared constants and helpers for the leading-one detector: index width and the
// all-ones code that stands for "no bit set".
package lod_pkg;

   localparam int LOD_WIDTH_DEF = 9;

   // Width needed to hold 0..width-1 plus one spare all-ones code.
   function automatic int lod_idx_w(input int width);
      return $clog2(width + 1);
   endfunction

   // Seven bits covers the widest index (WIDTH=64 gives IDX_W=7).
   function automatic logic [6:0] lod_zero_code(input int idx_w);
      logic [7:0] w_full;
      w_full = 8'((9'd1 << idx_w) - 9'd1);
      return w_full[6:0];
   endfunction

endpackage

// File: rtl/leading_one_detector_if.sv
// Bus between a word producer and the leading-one detector: the scanned word
// plus the combinational and registered results.
interface leading_one_detector_if
   import lod_pkg::*;
#(
   parameter int WIDTH = LOD_WIDTH_DEF
);
   localparam int IDX_W = lod_idx_w(WIDTH);

   logic [WIDTH-1:0] number_i;
   logic [IDX_W-1:0] index_o;
   logic             zero_o;
   logic [IDX_W-1:0] index_q_o;
   logic             zero_q_o;

   // No handshake: number_i is sampled every cycle and the results are always valid.
   modport master (
      output number_i,
      input  index_o,
      input  zero_o,
      input  index_q_o,
      input  zero_q_o
   );

   modport slave (
      input  number_i,
      output index_o,
      output zero_o,
      output index_q_o,
      output zero_q_o
   );

endinterface

// File: rtl/lod_tree.sv
// Recursive binary tree locating the highest set bit; each node prefers its
// upper half whenever that half holds any set bit.
module lod_tree #(
   parameter int WIDTH = 9,
   parameter int IDX_W = 4
) (
   input  logic [WIDTH-1:0] i_bits,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_idx
);

   generate
      if (WIDTH == 1) begin : g_leaf
         assign o_valid = i_bits[0];
         assign o_idx   = '0;
      end else begin : g_node
         localparam int LO_W = WIDTH / 2;
         localparam int HI_W = WIDTH - LO_W;
         // Indices reported by the upper child are relative to bit LO_W.
         localparam logic [IDX_W-1:0] LO_OFF = IDX_W'(LO_W);

         logic             w_hi_valid;
         logic [IDX_W-1:0] w_hi_idx;
         logic             w_lo_valid;
         logic [IDX_W-1:0] w_lo_idx;

         lod_tree #(
            .WIDTH (HI_W),
            .IDX_W (IDX_W)
         ) u_hi (
            .i_bits  (i_bits[WIDTH-1:LO_W]),
            .o_valid (w_hi_valid),
            .o_idx   (w_hi_idx)
         );

         lod_tree #(
            .WIDTH (LO_W),
            .IDX_W (IDX_W)
         ) u_lo (
            .i_bits  (i_bits[LO_W-1:0]),
            .o_valid (w_lo_valid),
            .o_idx   (w_lo_idx)
         );

         assign o_valid = w_hi_valid | w_lo_valid;
         assign o_idx   = w_hi_valid ? (w_hi_idx + LO_OFF) : w_lo_idx;
      end
   endgenerate

endmodule

// File: rtl/leading_one_detector.sv
// Leading-one detector: combinational MSB position of number_i plus a one-cycle
// registered copy; an all-zero word yields the all-ones index code.
module leading_one_detector
   import lod_pkg::*;
#(
   parameter int WIDTH = LOD_WIDTH_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   leading_one_detector_if.slave   bus
);

   localparam int IDX_W = lod_idx_w(WIDTH);
   localparam logic [IDX_W-1:0] ZERO_CODE = IDX_W'(lod_zero_code(IDX_W));

   logic             w_valid;
   logic [IDX_W-1:0] w_idx;
   logic [IDX_W-1:0] w_index;
   logic             w_zero;
   logic [IDX_W-1:0] r_index_q;
   logic             r_zero_q;

   lod_tree #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_tree (
      .i_bits  (bus.number_i),
      .o_valid (w_valid),
      .o_idx   (w_idx)
   );

   assign w_zero  = ~w_valid;
   assign w_index = w_valid ? w_idx : ZERO_CODE;

   // Reset loads the zero-input encoding so downstream sees a consistent pair.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_index_q <= ZERO_CODE;
         r_zero_q  <= 1'b1;
      end else begin
         r_index_q <= w_index;
         r_zero_q  <= w_zero;
      end
   end

   assign bus.index_o   = w_index;
   assign bus.zero_o    = w_zero;
   assign bus.index_q_o = r_index_q;
   assign bus.zero_q_o  = r_zero_q;

endmodule

// File: tb/tb_leading_one_detector.sv
// Bench for leading_one_detector at WIDTH=9 and WIDTH=16: log2 reference model
// with a registered-path expected queue, plus hand-computed spot values.
module tb_leading_one_detector;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   logic [7:0] exp_q[$];
   logic [7:0] exp16_q[$];

   leading_one_detector_if #(.WIDTH(9))  bus9 ();
   leading_one_detector_if #(.WIDTH(16)) bus16 ();

   leading_one_detector #(.WIDTH(9)) u_dut9 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus9)
   );

   leading_one_detector #(.WIDTH(16)) u_dut16 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus16)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "timeout");
   end

   // ---------------- reference model ----------------
   // floor(log2(n)) for n>0, otherwise 2^idx_w-1; returned as {zero, index}.
   function automatic logic [7:0] ref_code(input longint unsigned n, input int idx_w);
      int k;
      logic [7:0] code;
      if (n == 0) begin
         code = 8'((1 << idx_w) - 1);
         return {1'b1, code[6:0]};
      end
      k = 0;
      while (n > 1) begin
         n = n / 2;
         k++;
      end
      return {1'b0, 7'(k)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(posedge clk) begin
      exp_q.push_back(rst ? {1'b1, 7'd15} : ref_code(64'(bus9.number_i), 4));
      exp16_q.push_back(rst ? {1'b1, 7'd31} : ref_code(64'(bus16.number_i), 5));
   end

   always @(negedge clk) begin
      logic [7:0] e;
      e = ref_code(64'(bus9.number_i), 4);
      chk("comb9_index", 64'(bus9.index_o), 64'(e[6:0]));
      chk("comb9_zero", 64'(bus9.zero_o), 64'(e[7]));
      e = ref_code(64'(bus16.number_i), 5);
      chk("comb16_index", 64'(bus16.index_o), 64'(e[6:0]));
      chk("comb16_zero", 64'(bus16.zero_o), 64'(e[7]));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("reg9_index", 64'(bus9.index_q_o), 64'(e[6:0]));
         chk("reg9_zero", 64'(bus9.zero_q_o), 64'(e[7]));
      end
      if (exp16_q.size() > 0) begin
         e = exp16_q.pop_front();
         chk("reg16_index", 64'(bus16.index_q_o), 64'(e[6:0]));
         chk("reg16_zero", 64'(bus16.zero_q_o), 64'(e[7]));
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic [8:0] n9, input logic [15:0] n16, input logic r);
      @(posedge clk);
      #1;
      bus9.number_i  = n9;
      bus16.number_i = n16;
      rst            = r;
   endtask

   task automatic spot9(input logic [8:0] n, input int exp_idx, input logic exp_zero);
      drive(n, 16'h0, 1'b0);
      @(negedge clk);
      chk($sformatf("spot9_%03h_index", n), 64'(bus9.index_o), 64'(exp_idx));
      chk($sformatf("spot9_%03h_zero", n), 64'(bus9.zero_o), 64'(exp_zero));
   endtask

   task automatic spot16(input logic [15:0] n, input int exp_idx, input logic exp_zero);
      drive(9'h0, n, 1'b0);
      @(negedge clk);
      chk($sformatf("spot16_%04h_index", n), 64'(bus16.index_o), 64'(exp_idx));
      chk($sformatf("spot16_%04h_zero", n), 64'(bus16.zero_o), 64'(exp_zero));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      bus9.number_i  = 9'h0;
      bus16.number_i = 16'h0;

      drive(9'h1FF, 16'hFFFF, 1'b1);
      @(negedge clk);
      chk("reset_index_q", 64'(bus9.index_q_o), 64'd15);
      chk("reset_zero_q", 64'(bus9.zero_q_o), 64'd1);
      chk("reset_comb_index", 64'(bus9.index_o), 64'd8);

      // Spot values
      spot9(9'h000, 15, 1'b1);
      spot9(9'h001, 0, 1'b0);
      spot9(9'h002, 1, 1'b0);
      spot9(9'h003, 1, 1'b0);
      spot9(9'h0FF, 7, 1'b0);
      spot9(9'h100, 8, 1'b0);
      spot9(9'h1FF, 8, 1'b0);
      spot9(9'h055, 6, 1'b0);
      spot16(16'h8000, 15, 1'b0);
      spot16(16'h0000, 31, 1'b1);
      spot16(16'h0001, 0, 1'b0);
      spot16(16'h0123, 8, 1'b0);

      // Register latency
      drive(9'h010, 16'h0, 1'b0);
      drive(9'h001, 16'h0, 1'b0);
      @(negedge clk);
      chk("latency_first", 64'(bus9.index_q_o), 64'd4);
      drive(9'h0AA, 16'h0, 1'b0);
      @(negedge clk);
      chk("latency_second", 64'(bus9.index_q_o), 64'd0);

      // Reset held two edges with MSB set
      drive(9'h100, 16'h8000, 1'b1);
      drive(9'h100, 16'h8000, 1'b1);
      @(negedge clk);
      chk("rst_hold1_index_q", 64'(bus9.index_q_o), 64'd15);
      chk("rst_hold1_zero_q", 64'(bus9.zero_q_o), 64'd1);
      chk("rst_hold1_comb", 64'(bus9.index_o), 64'd8);
      drive(9'h100, 16'h8000, 1'b0);
      @(negedge clk);
      chk("rst_hold2_index_q", 64'(bus9.index_q_o), 64'd15);
      chk("rst_hold2_zero_q", 64'(bus9.zero_q_o), 64'd1);
      chk("rst16_index_q", 64'(bus16.index_q_o), 64'd31);
      drive(9'h020, 16'h0, 1'b0);
      @(negedge clk);
      chk("rst_release_index_q", 64'(bus9.index_q_o), 64'd8);
      chk("rst_release_zero_q", 64'(bus9.zero_q_o), 64'd0);
      chk("rst_release16_index_q", 64'(bus16.index_q_o), 64'd15);

      // Exhaustive sweep of the 9-bit space; random words for the 16-bit instance
      for (int n = 0; n < 512; n++) begin
         drive(9'(n), 16'($urandom_range(0, 65535)), 1'b0);
      end

      // Reset mid-stream for one edge
      for (int i = 0; i < 24; i++) begin
         drive(9'($urandom_range(1, 511)), 16'($urandom_range(0, 65535)), i == 12);
         if (i == 13) begin
            @(negedge clk);
            chk("midrst_index_q", 64'(bus9.index_q_o), 64'd15);
            chk("midrst_zero_q", 64'(bus9.zero_q_o), 64'd1);
         end
      end

      drive(9'h0, 16'h0, 1'b0);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
